// File: rtl/msu_pkg.sv
// Shared widths, word-count helpers and encodings for the MSU host-side transfer logic.
package msu_pkg;

  localparam int MSU_AXI_LEN         = 32;
  localparam int MSU_XFER_SIZE_WIDTH = 32;
  localparam int MSU_T_LEN           = 64;
  localparam int MSU_SQ_IN_BITS      = 1024;
  localparam int MSU_SQ_OUT_BITS     = 1024;
  localparam int MSU_DONE_TIMEOUT    = 16;

  typedef enum logic [1:0] {
    OK         = 2'd0,
    CFG        = 2'd1,
    EARLY_DONE = 2'd2,
    TIMEOUT    = 2'd3
  } msu_err_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_SEND,
    ST_RECV,
    ST_WAIT_DONE,
    ST_RESPOND
  } xfer_state_t;

  function automatic int in_count(int axi_len, int t_len, int sq_in_bits);
    return (2 * t_len) / axi_len + sq_in_bits / axi_len;
  endfunction

  function automatic int out_count(int axi_len, int t_len, int sq_out_bits);
    return t_len / axi_len + (sq_out_bits + axi_len - 1) / axi_len;
  endfunction

endpackage

// File: rtl/msu_host_xfer.sv
// Host-side MSU job driver: serialises one job onto the MSU input stream and
// collects the result stream into a parallel response with an error code.
//
// state        | meaning
// IDLE         | waiting for a command
// START        | one-cycle ap_start pulse
// SEND         | streaming t_start, t_final, sq_in (LS word first)
// RECV         | collecting t_current, sq_out (LS word first)
// WAIT_DONE    | waiting for ap_done, bounded by DONE_TIMEOUT
// RESPOND      | response held until rsp_ready
module msu_host_xfer
  import msu_pkg::*;
#(
  parameter int AXI_LEN           = MSU_AXI_LEN,
  parameter int C_XFER_SIZE_WIDTH = MSU_XFER_SIZE_WIDTH,
  parameter int T_LEN             = MSU_T_LEN,
  parameter int SQ_IN_BITS        = MSU_SQ_IN_BITS,
  parameter int SQ_OUT_BITS       = MSU_SQ_OUT_BITS,
  parameter int DONE_TIMEOUT      = MSU_DONE_TIMEOUT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [T_LEN-1:0]             cmd_t_start,
  input  logic [T_LEN-1:0]             cmd_t_final,
  input  logic [SQ_IN_BITS-1:0]        cmd_sq_in,
  output logic                         ap_start,
  input  logic                         ap_done,
  input  logic [C_XFER_SIZE_WIDTH-1:0] msu_in_xfer_size,
  input  logic [C_XFER_SIZE_WIDTH-1:0] msu_out_xfer_size,
  output logic                         m_axis_tvalid,
  input  logic                         m_axis_tready,
  output logic [AXI_LEN-1:0]           m_axis_tdata,
  output logic [AXI_LEN/8-1:0]         m_axis_tkeep,
  output logic                         m_axis_tlast,
  input  logic                         s_axis_tvalid,
  output logic                         s_axis_tready,
  input  logic [AXI_LEN-1:0]           s_axis_tdata,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [T_LEN-1:0]             rsp_t_current,
  output logic [SQ_OUT_BITS-1:0]       rsp_sq_out,
  output logic [1:0]                   rsp_err
);

  localparam int IN_COUNT  = in_count(AXI_LEN, T_LEN, SQ_IN_BITS);
  localparam int OUT_COUNT = out_count(AXI_LEN, T_LEN, SQ_OUT_BITS);
  localparam int SEND_BITS = IN_COUNT * AXI_LEN;
  localparam int RECV_BITS = OUT_COUNT * AXI_LEN;
  localparam int SCNT_W    = $clog2(IN_COUNT + 1);
  localparam int RCNT_W    = $clog2(OUT_COUNT + 1);
  localparam int TMO_W     = $clog2(DONE_TIMEOUT + 1);

  localparam logic [C_XFER_SIZE_WIDTH-1:0] IN_BYTES  = C_XFER_SIZE_WIDTH'(IN_COUNT * AXI_LEN / 8);
  localparam logic [C_XFER_SIZE_WIDTH-1:0] OUT_BYTES = C_XFER_SIZE_WIDTH'(OUT_COUNT * AXI_LEN / 8);

  xfer_state_t           state;
  msu_err_t              err_q;
  logic [SEND_BITS-1:0]  send_sr;
  logic [RECV_BITS-1:0]  recv_sr;
  logic [RECV_BITS-1:0]  recv_next;
  logic [RECV_BITS-1:0]  recv_aligned;
  logic [SCNT_W-1:0]     send_cnt;
  logic [RCNT_W-1:0]     recv_cnt;
  logic [RCNT_W-1:0]     recv_cnt_next;
  logic [TMO_W-1:0]      tmo_cnt;
  logic                  cfg_ok;
  logic                  recv_beat;
  logic                  recv_last;

  assign cfg_ok        = (msu_in_xfer_size == IN_BYTES) && (msu_out_xfer_size == OUT_BYTES);
  assign cmd_ready     = (state == ST_IDLE) && !reset;
  assign m_axis_tdata  = send_sr[AXI_LEN-1:0];
  assign m_axis_tkeep  = '1;
  assign rsp_t_current = recv_sr[T_LEN-1:0];
  assign rsp_sq_out    = recv_sr[T_LEN +: SQ_OUT_BITS];
  assign rsp_err       = err_q;

  // Words enter at the top; a partial capture is shifted down so the first
  // word received lands at bit 0, matching a complete capture.
  always_comb begin
    recv_beat     = (state == ST_RECV) && s_axis_tvalid;
    recv_last     = recv_beat && (recv_cnt == RCNT_W'(OUT_COUNT - 1));
    recv_next     = recv_sr;
    recv_cnt_next = recv_cnt;
    if (recv_beat) begin
      recv_next     = {s_axis_tdata, recv_sr[RECV_BITS-1:AXI_LEN]};
      recv_cnt_next = recv_cnt + 1'b1;
    end
    recv_aligned = recv_next >> (AXI_LEN * (OUT_COUNT - int'(recv_cnt_next)));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      err_q         <= OK;
      ap_start      <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      s_axis_tready <= 1'b0;
      rsp_valid     <= 1'b0;
      send_sr       <= '0;
      recv_sr       <= '0;
      send_cnt      <= '0;
      recv_cnt      <= '0;
      tmo_cnt       <= '0;
    end else begin
      ap_start <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            send_sr  <= SEND_BITS'({cmd_sq_in, cmd_t_final, cmd_t_start});
            recv_sr  <= '0;
            send_cnt <= '0;
            recv_cnt <= '0;
            tmo_cnt  <= '0;
            if (cfg_ok) begin
              state    <= ST_START;
              ap_start <= 1'b1;
            end else begin
              state     <= ST_RESPOND;
              rsp_valid <= 1'b1;
              err_q     <= CFG;
            end
          end
        end
        ST_START: begin
          if (ap_done) begin
            state     <= ST_RESPOND;
            rsp_valid <= 1'b1;
            err_q     <= EARLY_DONE;
          end else begin
            state         <= ST_SEND;
            m_axis_tvalid <= 1'b1;
            m_axis_tlast  <= (IN_COUNT == 1);
          end
        end
        ST_SEND: begin
          if (ap_done) begin
            state         <= ST_RESPOND;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            rsp_valid     <= 1'b1;
            err_q         <= EARLY_DONE;
          end else if (m_axis_tready) begin
            send_sr  <= send_sr >> AXI_LEN;
            send_cnt <= send_cnt + 1'b1;
            if (m_axis_tlast) begin
              state         <= ST_RECV;
              m_axis_tvalid <= 1'b0;
              m_axis_tlast  <= 1'b0;
              s_axis_tready <= 1'b1;
            end else begin
              m_axis_tlast <= (send_cnt == SCNT_W'(IN_COUNT - 2));
            end
          end
        end
        ST_RECV: begin
          recv_cnt <= recv_cnt_next;
          if (ap_done) begin
            recv_sr       <= recv_aligned;
            s_axis_tready <= 1'b0;
            state         <= ST_RESPOND;
            rsp_valid     <= 1'b1;
            if (recv_last) err_q <= OK;
            else           err_q <= EARLY_DONE;
          end else begin
            recv_sr <= recv_next;
            if (recv_last) begin
              s_axis_tready <= 1'b0;
              state         <= ST_WAIT_DONE;
            end
          end
        end
        ST_WAIT_DONE: begin
          if (ap_done) begin
            state     <= ST_RESPOND;
            rsp_valid <= 1'b1;
            err_q     <= OK;
          end else if (tmo_cnt == TMO_W'(DONE_TIMEOUT - 1)) begin
            state     <= ST_RESPOND;
            rsp_valid <= 1'b1;
            err_q     <= TIMEOUT;
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        ST_RESPOND: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_msu_host_xfer.sv
// Scoreboard bench for msu_host_xfer: a behavioural MSU feeds results back,
// expected stream words and responses are queued at stimulus time.
module tb_msu_host_xfer;
  import msu_pkg::*;

  localparam int IN_CNT  = 36;
  localparam int OUT_CNT = 34;
  localparam int DTMO    = 16;
  localparam int M_NEXT  = 0;  // ap_done the cycle after the last result beat
  localparam int M_SAME  = 1;  // ap_done together with the last result beat
  localparam int M_NONE  = 2;  // ap_done withheld

  typedef struct {
    logic [63:0]   tcur;
    logic [1023:0] sq;
    msu_err_t      err;
  } rsp_t;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [63:0]   cmd_t_start = '0;
  logic [63:0]   cmd_t_final = '0;
  logic [1023:0] cmd_sq_in = '0;
  logic          ap_start;
  logic          ap_done = 1'b0;
  logic [31:0]   msu_in_xfer_size = 32'd144;
  logic [31:0]   msu_out_xfer_size = 32'd136;
  logic          m_axis_tvalid;
  logic          m_axis_tready = 1'b0;
  logic [31:0]   m_axis_tdata;
  logic [3:0]    m_axis_tkeep;
  logic          m_axis_tlast;
  logic          s_axis_tvalid = 1'b0;
  logic          s_axis_tready;
  logic [31:0]   s_axis_tdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [63:0]   rsp_t_current;
  logic [1023:0] rsp_sq_out;
  logic [1:0]    rsp_err;

  logic [31:0] exp_words[$];
  rsp_t        exp_rsp[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic [1023:0] sq_pat;

  msu_host_xfer dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_t_start(cmd_t_start), .cmd_t_final(cmd_t_final), .cmd_sq_in(cmd_sq_in),
    .ap_start(ap_start), .ap_done(ap_done),
    .msu_in_xfer_size(msu_in_xfer_size), .msu_out_xfer_size(msu_out_xfer_size),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tkeep(m_axis_tkeep), .m_axis_tlast(m_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_t_current(rsp_t_current), .rsp_sq_out(rsp_sq_out), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    cmd_valid        = 1'b0;
    ap_done          = 1'b0;
    m_axis_tready    = 1'b0;
    s_axis_tvalid    = 1'b0;
    s_axis_tdata     = '0;
    rsp_ready        = 1'b0;
    msu_in_xfer_size = 32'd144;
  endtask

  task automatic run_job(input logic [63:0] ts, input logic [63:0] tf, input logic [1023:0] sqi,
                         input logic [63:0] tcur, input logic [1023:0] sqo, input int n_res,
                         input int mode, input bit bp, input bit cfg_bad, input int abort_at);
    logic [1151:0] job;
    logic [1087:0] res;
    logic [1087:0] mask;
    logic [31:0]   w;
    logic [31:0]   stall_data;
    logic          stall_last;
    rsp_t          r;
    int it, acc_it, start_it, tv_it, str_it, last_it, rise_it, sent, beats, starts, exp_lat;
    bit got, aborted, done_pending, stall;

    job = {sqi, tf, ts};
    res = {sqo, tcur};
    mask = '1;
    mask = mask >> ((OUT_CNT - n_res) * 32);
    if (!cfg_bad)
      for (int i = 0; i < IN_CNT; i++) begin
        w = job[i*32 +: 32];
        exp_words.push_back(w);
      end
    r.tcur = cfg_bad ? 64'd0 : (res[63:0] & mask[63:0]);
    r.sq   = cfg_bad ? 1024'd0 : (res[1087:64] & mask[1087:64]);
    if (cfg_bad)             r.err = CFG;
    else if (mode == M_NONE) r.err = TIMEOUT;
    else if (n_res < OUT_CNT) r.err = EARLY_DONE;
    else                     r.err = OK;
    if (abort_at < 0) exp_rsp.push_back(r);

    cmd_t_start = ts;
    cmd_t_final = tf;
    cmd_sq_in   = sqi;
    msu_in_xfer_size = cfg_bad ? 32'd140 : 32'd144;
    cmd_valid = 1'b1;

    it = 0; acc_it = -1; start_it = -1; tv_it = -1; str_it = -1; last_it = -1; rise_it = -1;
    sent = 0; beats = 0; starts = 0;
    got = 0; aborted = 0; done_pending = 0; stall = 0;
    stall_data = '0; stall_last = 1'b0;

    while (!got && !aborted && it < 3000) begin
      if (acc_it >= 0) cmd_valid = 1'b0;
      ap_done = 1'b0;
      if (done_pending) begin
        ap_done = 1'b1;
        done_pending = 0;
      end
      m_axis_tready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      s_axis_tvalid = (sent < n_res) && (bp ? ($urandom_range(0, 1) == 1) : 1'b1);
      if (sent < n_res) begin
        w = res[sent*32 +: 32];
        s_axis_tdata = w;
      end else begin
        s_axis_tdata = '0;
      end
      rsp_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;

      if (stall) begin
        chk("stall_tvalid", m_axis_tvalid, 1);
        chk("stall_tdata", m_axis_tdata, stall_data);
        chk("stall_tlast", m_axis_tlast, stall_last);
        stall = 0;
      end
      if (ap_start) begin
        starts++;
        if (start_it < 0) start_it = it;
      end
      if (m_axis_tvalid && tv_it < 0) tv_it = it;
      if (s_axis_tready && str_it < 0) str_it = it;
      if (rsp_valid && rise_it < 0) rise_it = it;
      if (cmd_valid && cmd_ready && acc_it < 0) acc_it = it;

      if (m_axis_tvalid && m_axis_tready) begin
        if (exp_words.size() == 0) chk("tx_extra", 1, 0);
        else begin
          w = exp_words.pop_front();
          chk("tx_data", m_axis_tdata, w);
          chk("tx_last", m_axis_tlast, exp_words.size() == 0);
          chk("tx_keep", m_axis_tkeep, 4'hF);
        end
        beats++;
        if (beats == abort_at) aborted = 1;
      end else if (m_axis_tvalid) begin
        stall = 1;
        stall_data = m_axis_tdata;
        stall_last = m_axis_tlast;
      end

      if (s_axis_tvalid && s_axis_tready) begin
        if (sent == n_res - 1) begin
          last_it = it;
          if (mode == M_NEXT) done_pending = 1;
          else if (mode == M_SAME) ap_done = 1'b1;
        end
        sent++;
      end

      if (rsp_valid && rsp_ready) begin
        got = 1;
        if (exp_rsp.size() == 0) chk("rsp_extra", 1, 0);
        else begin
          r = exp_rsp.pop_front();
          chk("rsp_err", rsp_err, r.err);
          chk("rsp_tcur", rsp_t_current, r.tcur);
          for (int k = 0; k < 32; k++) chk("rsp_sq_word", rsp_sq_out[k*32 +: 32], r.sq[k*32 +: 32]);
        end
      end
      @(posedge clk);
      #1;
      it++;
    end

    if (abort_at >= 0) begin
      chk("abort_reached", aborted, 1);
    end else begin
      chk("rsp_seen", got, 1);
      if (cfg_bad) begin
        chk("cfg_no_start", starts, 0);
        chk("cfg_lat", (rise_it - acc_it) <= 2 && rise_it > acc_it, 1);
      end else begin
        if (mode == M_NONE)      exp_lat = DTMO + 1;
        else if (mode == M_SAME) exp_lat = 1;
        else                     exp_lat = 2;
        chk("start_lat", start_it - acc_it, 1);
        chk("start_cnt", starts, 1);
        chk("tvalid_lat", tv_it - acc_it, 2);
        if (!bp) chk("srdy_lat", str_it - acc_it, 38);
        chk("rsp_lat", rise_it - last_it, exp_lat);
        chk("tx_left", exp_words.size(), 0);
      end
    end
    idle_inputs();
  endtask

  initial begin
    for (int k = 0; k < 32; k++) sq_pat[k*32 +: 32] = 32'h5000_0000 + 32'(k);
    idle_inputs();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ap_start", ap_start, 0);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    reset = 1'b0;
    #1;
    chk("cmd_ready_after_rst", cmd_ready, 1);

    // nominal, then the same job under random stalls on both streams
    run_job(64'd0, 64'd5, 1024'h3, 64'd5, 1024'hABCD, OUT_CNT, M_NEXT, 0, 0, -1);
    run_job(64'd0, 64'd5, 1024'h3, 64'd5, 1024'hABCD, OUT_CNT, M_NEXT, 1, 0, -1);
    run_job(64'd1, 64'd9, sq_pat, 64'd9, sq_pat, OUT_CNT, M_NEXT, 0, 1, -1);
    run_job(64'd7, 64'h1_0000_0064, ~sq_pat, 64'h1_0000_0064, sq_pat, 10, M_NEXT, 0, 0, -1);
    run_job(64'd3, 64'd12, sq_pat, 64'hDEAD_BEEF_0000_000C, ~sq_pat, OUT_CNT, M_SAME, 0, 0, -1);
    run_job(64'd2, 64'd8, 1024'h55, 64'd8, 1024'h77, OUT_CNT, M_NONE, 0, 0, -1);

    // reset while the job stream is at word 20
    run_job(64'd4, 64'd6, sq_pat, 64'd6, sq_pat, OUT_CNT, M_NEXT, 0, 0, 20);
    exp_words.delete();
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_ap_start", ap_start, 0);
    chk("mid_m_tvalid", m_axis_tvalid, 0);
    chk("mid_m_tlast", m_axis_tlast, 0);
    chk("mid_m_tdata", m_axis_tdata, 0);
    chk("mid_s_tready", s_axis_tready, 0);
    chk("mid_rsp_valid", rsp_valid, 0);
    chk("mid_cmd_ready", cmd_ready, 0);
    reset = 1'b0;
    #1;
    chk("mid_cmd_ready_rel", cmd_ready, 1);
    run_job(64'd0, 64'd5, 1024'h3, 64'd5, 1024'hABCD, OUT_CNT, M_NEXT, 0, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
